multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle successor to the single-cycle instruction controller. It latches
//  the opcode, steps through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath
//  selects, plus explicit PC-write, fetch and memory handshakes.
//  It adds parametrised field widths, conditional-jump flag evaluation, a memory
//  wait/timeout counter and illegal-opcode reporting.
// PARAMETERS
//  OPC_W       6   opcode width, >=6; decode uses bits [OPC_W-1:OPC_W-6] (called op[5:0] below)
//  ALU_OP_W    3   alu_op width, 1..4; alu_op = op[ALU_OP_W-1:0]
//  MEM_TIMEOUT 15  max MEM-state cycles without mem_ready before abort, >=1
// PORTS
//  clk               in  1        rising-edge clock
//  rst               in  1        asynchronous, active-high reset
//  instr             in  OPC_W    opcode from instruction memory, valid when instr_ready
//  instr_ready       in  1        instruction fetch complete
//  mem_ready         in  1        data memory access complete
//  flag_z, flag_c    in  1 each   ALU zero/carry flags, sampled in DECODE
//  fetch_req         out 1        instruction fetch request
//  ir_load           out 1        datapath latches instruction operands
//  pc_write          out 1        PC register load enable
//  sel_pc_plus1/sel_pc_offset/sel_pc_const  out 1 each  PC source select, one-hot when pc_write
//  alu_op            out ALU_OP_W ALU operation
//  sel_alu_src_reg/sel_alu_src_const        out 1 each  ALU B operand select
//  mem_read, mem_write                      out 1 each  data memory strobes
//  sel_rf_in_alu/sel_rf_in_mem              out 1 each  register file write-data select
//  rf_write_en       out 1        register file write enable
//  illegal_op        out 1        one-cycle pulse, undefined opcode
//  mem_timeout       out 1        sticky, memory access aborted; cleared only by rst
//  state_dbg         out 3        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
// BEHAVIOUR
//  Opcode classes:
//   - R-type op[5:4]=00; I-type op[5:4]=01
//   - MEM op[5:3]=100: fn op[2:1]=00 STM, 01 LDM, 1x illegal
//   - CJ op[5:3]=101: cond op[2:1]=00 Z, 01 !Z, 10 C, 11 !C
//   - UJ op[5:2]=1100; all other opcodes are illegal
//  Reset:
//   - state=FETCH, opcode reg=0, wait counter=0, mem_timeout=0.
//   - While rst is high, all outputs are 0, including fetch_req.
//   - rst asserted mid-operation drops all strobes immediately (async).
//  State machine:
//   - FETCH: fetch_req=1 until instr_ready.
//     On instr_ready: ir_load=1, latch opcode, go to DECODE.
//   - DECODE:
//     - UJ: pc_write, sel_pc_const; go to FETCH.
//     - CJ taken: pc_write, sel_pc_offset. CJ not taken: pc_write, sel_pc_plus1.
//       Both go to FETCH; sel_rf_in_alu=1; rf_write_en=0.
//     - Illegal: illegal_op=1, pc_write, sel_pc_plus1; go to FETCH.
//     - Otherwise go to EXEC.
//   - EXEC:
//     - R-type: alu_op, sel_alu_src_reg. I-type: alu_op, sel_alu_src_const.
//       Both go to WB.
//     - MEM: sel_alu_src_const (address); clear counter; go to MEM.
//   - MEM: mem_write (STM) or mem_read (LDM) held high until mem_ready.
//     - Counter increments each cycle without mem_ready.
//     - mem_ready: STM does pc_write, sel_pc_plus1, goes to FETCH. LDM goes to WB.
//     - Counter == MEM_TIMEOUT with no mem_ready: strobe drops next cycle;
//       set mem_timeout; pc_write, sel_pc_plus1; go to FETCH.
//     - mem_ready in the same cycle the limit is hit: ready wins, no timeout.
//   - WB: rf_write_en=1; sel_rf_in_alu (R/I) or sel_rf_in_mem (LDM);
//     pc_write, sel_pc_plus1; go to FETCH.
//  Output timing:
//   - Selects (alu_op, alu/rf selects) are held constant from EXEC to end of instruction.
//   - Strobes (pc_write, rf_write_en, mem_*, ir_load, illegal_op) are high only
//     in the states listed above.
//   - All outputs are decoded from state plus the registered opcode; no
//     combinational path from instr.
//  Latency with instr_ready and mem_ready immediate:
//   - jump/illegal 2 cycles; R/I 4; STM 4; LDM 5.
// TESTING
//  1. rst pulse mid-MEM of LDM -> mem_read=0 same cycle; after release, state_dbg=0, fetch_req=1.
//  2. instr=6'b000010, ready immediately -> EXEC: alu_op=3'b010, sel_alu_src_reg;
//     WB: rf_write_en+sel_rf_in_alu+pc_write+plus1; 4 cycles total.
//  3. LDM 6'b100010, mem_ready after 3 cycles -> mem_read high 4 cycles;
//     WB sel_rf_in_mem+rf_write_en; no timeout.
//  4. STM 6'b100000, mem_ready never -> mem_write high MEM_TIMEOUT+1 cycles;
//     mem_timeout=1 sticky; PC+1; next fetch.
//  5. CJ 6'b101000 with flag_z=1 -> pc_write+sel_pc_offset; flag_z=0 -> sel_pc_plus1;
//     UJ 6'b110000 -> sel_pc_const. All 2 cycles, rf_write_en=0.
//  6. instr=6'b111111 and 6'b100100 -> illegal_op single pulse in DECODE; PC+1;
//     no mem/rf strobes.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> fetch/datapath/memory signal bundle
interface multicycle_controller_if #(
   parameter int OPC_W    = 6,
   parameter int ALU_OP_W = 3
);
   logic [OPC_W-1:0]    instr;
   logic                instr_ready;
   logic                mem_ready;
   logic                flag_z;
   logic                flag_c;
   logic                fetch_req;
   logic                ir_load;
   logic                pc_write;
   logic                sel_pc_plus1;
   logic                sel_pc_offset;
   logic                sel_pc_const;
   logic [ALU_OP_W-1:0] alu_op;
   logic                sel_alu_src_reg;
   logic                sel_alu_src_const;
   logic                mem_read;
   logic                mem_write;
   logic                sel_rf_in_alu;
   logic                sel_rf_in_mem;
   logic                rf_write_en;
   logic                illegal_op;
   logic                mem_timeout;
   logic [2:0]          state_dbg;

   modport master (
      input  instr, instr_ready, mem_ready, flag_z, flag_c,
      output fetch_req, ir_load, pc_write, sel_pc_plus1, sel_pc_offset, sel_pc_const,
             alu_op, sel_alu_src_reg, sel_alu_src_const, mem_read, mem_write,
             sel_rf_in_alu, sel_rf_in_mem, rf_write_en, illegal_op, mem_timeout, state_dbg
   );

   modport slave (
      output instr, instr_ready, mem_ready, flag_z, flag_c,
      input  fetch_req, ir_load, pc_write, sel_pc_plus1, sel_pc_offset, sel_pc_const,
             alu_op, sel_alu_src_reg, sel_alu_src_const, mem_read, mem_write,
             sel_rf_in_alu, sel_rf_in_mem, rf_write_en, illegal_op, mem_timeout, state_dbg
   );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB instruction controller
module multicycle_controller #(
   parameter int OPC_W       = 6,
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.master bus
);
   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;

   localparam int               CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   logic [2:0]       state, next_state;
   logic [5:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             timeout_q;

   logic is_r, is_i, is_stm, is_ldm, is_mem, is_cj, is_uj, is_ill, cj_taken;
   logic in_body, mem_abort;

   assign is_r     = (op_q[5:4] == 2'b00);
   assign is_i     = (op_q[5:4] == 2'b01);
   assign is_stm   = (op_q[5:1] == 5'b10000);
   assign is_ldm   = (op_q[5:1] == 5'b10001);
   assign is_mem   = is_stm | is_ldm;
   assign is_cj    = (op_q[5:3] == 3'b101);
   assign is_uj    = (op_q[5:2] == 4'b1100);
   assign is_ill   = !(is_r | is_i | is_mem | is_cj | is_uj);
   // op[2] picks carry vs zero, op[1] inverts the condition
   assign cj_taken = op_q[2] ? (bus.flag_c ^ op_q[1]) : (bus.flag_z ^ op_q[1]);

   assign in_body   = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);
   assign mem_abort = (state == S_MEM) && !bus.mem_ready && (cnt == CNT_MAX);

   assign bus.mem_timeout = timeout_q;
   assign bus.state_dbg   = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         op_q      <= '0;
         cnt       <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_FETCH && bus.instr_ready)
            op_q <= bus.instr[OPC_W-1 -: 6];
         if (state == S_EXEC)
            cnt <= '0;
         else if (state == S_MEM && !bus.mem_ready && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         if (mem_abort)
            timeout_q <= 1'b1;
      end
   end

   // Everything is gated by rst so strobes vanish the moment reset is raised
   always_comb begin
      next_state            = state;
      bus.fetch_req         = 1'b0;
      bus.ir_load           = 1'b0;
      bus.pc_write          = 1'b0;
      bus.sel_pc_plus1      = 1'b0;
      bus.sel_pc_offset     = 1'b0;
      bus.sel_pc_const      = 1'b0;
      bus.alu_op            = '0;
      bus.sel_alu_src_reg   = 1'b0;
      bus.sel_alu_src_const = 1'b0;
      bus.mem_read          = 1'b0;
      bus.mem_write         = 1'b0;
      bus.sel_rf_in_alu     = 1'b0;
      bus.sel_rf_in_mem     = 1'b0;
      bus.rf_write_en       = 1'b0;
      bus.illegal_op        = 1'b0;
      if (!rst) begin
         if (in_body) begin
            if (is_r || is_i)
               bus.alu_op = op_q[ALU_OP_W-1:0];
            bus.sel_alu_src_reg   = is_r;
            bus.sel_alu_src_const = is_i | is_mem;
            bus.sel_rf_in_alu     = is_r | is_i;
            bus.sel_rf_in_mem     = is_ldm;
         end
         case (state)
            S_FETCH: begin
               bus.fetch_req = 1'b1;
               if (bus.instr_ready) begin
                  bus.ir_load = 1'b1;
                  next_state  = S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_uj) begin
                  bus.pc_write     = 1'b1;
                  bus.sel_pc_const = 1'b1;
                  next_state       = S_FETCH;
               end else if (is_cj) begin
                  bus.pc_write      = 1'b1;
                  bus.sel_pc_offset = cj_taken;
                  bus.sel_pc_plus1  = !cj_taken;
                  bus.sel_rf_in_alu = 1'b1;
                  next_state        = S_FETCH;
               end else if (is_ill) begin
                  bus.illegal_op   = 1'b1;
                  bus.pc_write     = 1'b1;
                  bus.sel_pc_plus1 = 1'b1;
                  next_state       = S_FETCH;
               end else begin
                  next_state = S_EXEC;
               end
            end
            S_EXEC: next_state = is_mem ? S_MEM : S_WB;
            S_MEM: begin
               bus.mem_write = is_stm;
               bus.mem_read  = is_ldm;
               if (bus.mem_ready) begin
                  if (is_stm) begin
                     bus.pc_write     = 1'b1;
                     bus.sel_pc_plus1 = 1'b1;
                     next_state       = S_FETCH;
                  end else begin
                     next_state = S_WB;
                  end
               end else if (mem_abort) begin
                  bus.pc_write     = 1'b1;
                  bus.sel_pc_plus1 = 1'b1;
                  next_state       = S_FETCH;
               end
            end
            S_WB: begin
               bus.rf_write_en  = 1'b1;
               bus.pc_write     = 1'b1;
               bus.sel_pc_plus1 = 1'b1;
               next_state       = S_FETCH;
            end
            default: next_state = S_FETCH;
         endcase
      end
   end
endmodule
